// File: rtl/beep_pkg.sv
// -----------------------------------------------------------------------------
// beep_pkg
// Shared definitions for the note-sequence beeper:
//   - state_e     : sequencer states (IDLE, TONE, GAP, DONE)
//   - len_w/idx_w : width helpers for the len input and note_idx output
//   - DEF_*       : default tick constants for a 1 kHz system clock
// -----------------------------------------------------------------------------
package beep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Defaults for a 1 kHz clock: 250 ms notes, no gap, 250 Hz / 500 Hz tones
    localparam int DEF_NOTE_TICKS = 250;
    localparam int DEF_GAP_TICKS  = 0;
    localparam int DEF_HALF_LO    = 2;
    localparam int DEF_HALF_HI    = 1;

    // Width able to hold the values 0..notes
    function automatic int len_w(input int notes);
        return $clog2(notes + 1);
    endfunction

    // Width able to index notes 0..notes-1, never narrower than one bit
    function automatic int idx_w(input int notes);
        return (notes > 1) ? $clog2(notes) : 1;
    endfunction

endpackage

// File: rtl/tone_gen.sv
// -----------------------------------------------------------------------------
// tone_gen
// Square-wave generator with two selectable half-periods.
// Ports:
//   clk_i    : system clock
//   st_i     : asynchronous active-low reset
//   en_i     : run enable; when low the output is forced to 0 and the
//              half-period counter is cleared, so the next enabled cycle
//              starts a fresh wave beginning with a low phase
//   sel_hi_i : 1 selects HALF_HI, 0 selects HALF_LO
//   sq_o     : registered square wave
// -----------------------------------------------------------------------------
module tone_gen
    import beep_pkg::*;
#(
    parameter int HALF_LO = DEF_HALF_LO,
    parameter int HALF_HI = DEF_HALF_HI,
    localparam int HALF_MAX = (HALF_LO > HALF_HI) ? HALF_LO : HALF_HI,
    localparam int HC_W     = $clog2(HALF_MAX + 1)
) (
    input  logic clk_i,
    input  logic st_i,
    input  logic en_i,
    input  logic sel_hi_i,
    output logic sq_o
);

    logic [HC_W-1:0] hc_q;
    logic [HC_W-1:0] hc_d;
    logic [HC_W-1:0] half_last_s;
    logic            sq_q;
    logic            sq_d;

    // Half-period counter and toggle decision
    always_comb begin
        half_last_s = sel_hi_i ? HC_W'(HALF_HI - 1) : HC_W'(HALF_LO - 1);
        if (!en_i) begin
            hc_d = '0;
            sq_d = 1'b0;
        end else if (hc_q == half_last_s) begin
            hc_d = '0;
            sq_d = ~sq_q;
        end else begin
            hc_d = hc_q + HC_W'(1'b1);
            sq_d = sq_q;
        end
    end

    // Counter and wave registers
    always_ff @(posedge clk_i or negedge st_i) begin
        if (!st_i) begin
            hc_q <= '0;
            sq_q <= 1'b0;
        end else begin
            hc_q <= hc_d;
            sq_q <= sq_d;
        end
    end

    assign sq_o = sq_q;

endmodule

// File: rtl/beep_seq.sv
// -----------------------------------------------------------------------------
// beep_seq
// Plays a sequence of up to NOTES notes (each low or high tone, NOTE_TICKS
// cycles long) with an optional GAP_TICKS silence between notes.
// Ports:
//   clk_i      : system clock (1 kHz nominal)
//   st_i       : asynchronous active-low reset
//   start_i    : one-cycle start request, honoured only in IDLE or DONE
//   abort_i    : return to IDLE immediately; wins over start_i
//   pattern_i  : bit i=1 -> note i high tone; latched on accepted start
//   len_i      : notes to play, clamped to NOTES; latched on accepted start
//   beep_o     : buzzer drive
//   busy_o     : high while in TONE or GAP
//   over_o     : sticky completion flag (high in DONE)
//   note_idx_o : index of the current note
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module beep_seq
    import beep_pkg::*;
#(
    parameter int NOTES      = 4,
    parameter int NOTE_TICKS = DEF_NOTE_TICKS,
    parameter int GAP_TICKS  = DEF_GAP_TICKS,
    parameter int HALF_LO    = DEF_HALF_LO,
    parameter int HALF_HI    = DEF_HALF_HI,
    parameter int CNT_W      = 16,
    localparam int LEN_W     = len_w(NOTES),
    localparam int IDX_W     = idx_w(NOTES)
) (
    input  logic             clk_i,
    input  logic             st_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [NOTES-1:0] pattern_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             beep_o,
    output logic             busy_o,
    output logic             over_o,
    output logic [IDX_W-1:0] note_idx_o
);

    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(NOTES);
    localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
    // Unreachable when GAP_TICKS is 0; kept in range anyway
    localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_TICKS > 0) ? CNT_W'(GAP_TICKS - 1) : '0;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   nc_q, nc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NOTES-1:0]   pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               busy_q, busy_d;
    logic               over_q, over_d;

    logic [LEN_W-1:0]   len_clamp_s;
    logic               note_end_s;
    logic               gap_end_s;
    logic               last_note_s;
    logic               tone_en_s;

    // Decode of the current position inside a note or gap
    always_comb begin
        len_clamp_s = (len_i > LEN_MAX) ? LEN_MAX : len_i;
        note_end_s  = (state_q == ST_TONE) && (nc_q == NOTE_LAST);
        gap_end_s   = (state_q == ST_GAP) && (nc_q == GAP_LAST);
        last_note_s = ((LEN_W'(idx_q) + LEN_W'(1'b1)) == len_q);
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge st_i) begin
        if (!st_i) begin
            state_q   <= ST_IDLE;
            nc_q      <= '0;
            idx_q     <= '0;
            pattern_q <= '0;
            len_q     <= '0;
        end else begin
            state_q   <= state_d;
            nc_q      <= nc_d;
            idx_q     <= idx_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
        end
    end

    // Next-state logic; nc restarts at 0 on every state or note entry
    always_comb begin
        state_d   = state_q;
        nc_d      = nc_q;
        idx_d     = idx_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        if (abort_i) begin
            state_d = ST_IDLE;
            nc_d    = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        pattern_d = pattern_i;
                        len_d     = len_clamp_s;
                        idx_d     = '0;
                        nc_d      = '0;
                        state_d   = (len_clamp_s == '0) ? ST_DONE : ST_TONE;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_TONE: begin
                    if (note_end_s) begin
                        nc_d = '0;
                        if (last_note_s) begin
                            state_d = ST_DONE;
                        end else if (GAP_TICKS > 0) begin
                            state_d = ST_GAP;
                        end else begin
                            idx_d = idx_q + IDX_W'(1'b1);
                        end
                    end else begin
                        nc_d = nc_q + CNT_W'(1'b1);
                    end
                end
                ST_GAP: begin
                    if (gap_end_s) begin
                        nc_d    = '0;
                        idx_d   = idx_q + IDX_W'(1'b1);
                        state_d = ST_TONE;
                    end else begin
                        nc_d = nc_q + CNT_W'(1'b1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    nc_d    = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so the registered outputs line up
    // with the state they describe; the tone only keeps running while the
    // same note continues, so every note entry restarts the wave at 0
    always_comb begin
        busy_d    = (state_d == ST_TONE) || (state_d == ST_GAP);
        over_d    = (state_d == ST_DONE);
        tone_en_s = (state_q == ST_TONE) && !note_end_s && !abort_i;
    end

    // Status output registers
    always_ff @(posedge clk_i or negedge st_i) begin
        if (!st_i) begin
            busy_q <= 1'b0;
            over_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            over_q <= over_d;
        end
    end

    tone_gen #(
        .HALF_LO (HALF_LO),
        .HALF_HI (HALF_HI)
    ) u_tone_gen (
        .clk_i    (clk_i),
        .st_i     (st_i),
        .en_i     (tone_en_s),
        .sel_hi_i (pattern_q[idx_q]),
        .sq_o     (beep_o)
    );

    assign busy_o     = busy_q;
    assign over_o     = over_q;
    assign note_idx_o = idx_q;

endmodule
